// File: rtl/cog_vin.sv
// Cog video capture: samples one 8-pin group at the pixel rate, palette-decodes
// each byte to a 1/2-bit index and packs indices LSB-first into 32-bit words.
// Optional macro COG_VIN_SYNC_EN adds a two-stage input synchronizer on pin_in.
module cog_vin (
  input  logic        clk_cog,
  input  logic        res,
  input  logic        setvin,
  input  logic        setscl,
  input  logic        setpal,
  input  logic [31:0] data,
  input  logic [31:0] pin_in,
  input  logic        take,
  output logic [31:0] word_out,
  output logic        valid,
  output logic        overrun,
  output logic        mismatch,
  output logic        busy
);

  localparam int unsigned CntW  = 9;   // pixel period up to 256
  localparam int unsigned SetW  = 13;  // word period up to 4096
  localparam int unsigned WordW = 32;

  // Configuration registers (only the used vin fields are kept)
  logic [1:0]       r_en;
  logic             r_bpp2;
  logic [1:0]       r_grp;
  logic [7:0]       r_mask;
  logic [19:0]      r_scl;
  logic [31:0]      r_pal;

  // Capture state
  logic [CntW-1:0]  r_cnt;
  logic [SetW-1:0]  r_set;
  logic [WordW-1:0] r_sr;

  logic [31:0]      w_pin;
  logic [7:0]       w_raw;
  logic [7:0]       w_byte;
  logic [1:0]       w_idx;
  logic             w_match;
  logic [CntW-1:0]  w_p;
  logic [SetW-1:0]  w_f;
  logic             w_active;
  logic             w_tick;
  logic             w_bound;
  logic [WordW-1:0] w_sr_shift;
  logic [WordW-1:0] w_sr_tick;
  logic [CntW-1:0]  w_cnt_nxt;
  logic [SetW-1:0]  w_set_nxt;

`ifdef COG_VIN_SYNC_EN
  logic [31:0] r_pin_s1;
  logic [31:0] r_pin_s2;

  // Two-flop synchronizer for asynchronous pin inputs
  always_ff @(posedge clk_cog) begin
    if (res) begin
      r_pin_s1 <= '0;
      r_pin_s2 <= '0;
    end else begin
      r_pin_s1 <= pin_in;
      r_pin_s2 <= r_pin_s1;
    end
  end

  assign w_pin = r_pin_s2;
`else
  assign w_pin = pin_in;
`endif

  // Pin group select and mask
  always_comb begin
    w_raw = 8'h00;
    case (r_grp)
      2'd0:    w_raw = w_pin[7:0];
      2'd1:    w_raw = w_pin[15:8];
      2'd2:    w_raw = w_pin[23:16];
      default: w_raw = w_pin[31:24];
    endcase
    w_byte = w_raw & r_mask;
  end

  // Palette match: scanning downward leaves the lowest matching entry
  always_comb begin
    w_idx   = 2'd0;
    w_match = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if ((r_bpp2 || (i < 2)) && (w_byte == (r_pal[8*i +: 8] & r_mask))) begin
        w_idx   = 2'(i);
        w_match = 1'b1;
      end
    end
  end

  // Zero in a scale field encodes the full power-of-two period
  assign w_p = (r_scl[19:12] == 8'd0)  ? CntW'(256)  : CntW'(r_scl[19:12]);
  assign w_f = (r_scl[11:0]  == 12'd0) ? SetW'(4096) : SetW'(r_scl[11:0]);

  assign w_active = |r_en;
  assign busy     = w_active;
  assign w_tick   = w_active && !setvin && (r_cnt == CntW'(1));
  assign w_bound  = w_active && !setvin && (r_set == SetW'(1));

  always_comb begin
    w_sr_shift = r_bpp2 ? {w_idx, r_sr[WordW-1:2]} : {w_idx[0], r_sr[WordW-1:1]};
    w_sr_tick  = w_tick ? w_sr_shift : r_sr;
    w_cnt_nxt  = ((r_cnt == CntW'(1)) || (r_set == SetW'(1))) ? w_p : r_cnt - CntW'(1);
    w_set_nxt  = (r_set == SetW'(1)) ? w_f : r_set - SetW'(1);
  end

  // Configuration writes
  always_ff @(posedge clk_cog) begin
    if (res) begin
      r_en   <= '0;
      r_bpp2 <= 1'b0;
      r_grp  <= '0;
      r_mask <= '0;
      r_scl  <= '0;
      r_pal  <= '0;
    end else begin
      if (setvin) begin
        r_en   <= data[30:29];
        r_bpp2 <= data[28];
        r_grp  <= data[10:9];
        r_mask <= data[7:0];
      end
      if (setscl) r_scl <= data[19:0];
      if (setpal) r_pal <= data;
    end
  end

  // Counters, shift register, word handoff and status flags
  always_ff @(posedge clk_cog) begin
    if (res) begin
      r_cnt    <= '0;
      r_set    <= '0;
      r_sr     <= '0;
      word_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      mismatch <= 1'b0;
    end else if (setvin) begin
      r_cnt    <= w_p;
      r_set    <= w_f;
      r_sr     <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      if (w_active) begin
        r_cnt <= w_cnt_nxt;
        r_set <= w_set_nxt;
        if (w_tick && !w_match) mismatch <= 1'b1;
      end
      if (w_bound) begin
        word_out <= w_sr_tick;
        r_sr     <= '0;
        valid    <= 1'b1;
        if (valid && !take) overrun <= 1'b1;
      end else begin
        r_sr <= w_sr_tick;
        if (take) valid <= 1'b0;
      end
    end
  end

endmodule
